// File: rtl/shift_exec_stage_pkg.sv
// Shared constants and types for the execute-stage shift unit.
// The optional rotate path is selected with SHIFT_EXEC_ROTATE_EN.
package shift_exec_stage_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_ROT  = 2'd2
    } state_t;

    // Left-shift amount that completes a right rotate by amt: (32 - amt) mod 32.
    function automatic logic [4:0] rot_back_amt(input logic [4:0] amt);
        return 5'd0 - amt;
    endfunction

endpackage

// File: rtl/shift_exec_stage_if.sv
// Upstream op handshake plus downstream result handshake of the shift stage.
interface shift_exec_stage_if;
    import shift_exec_stage_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [5:0]      funct;
    logic            rot;
    logic [4:0]      shamt;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
    logic [RAW-1:0]  rd_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [RAW-1:0]  rd_out;
    logic            err;

    modport master (
        output in_valid, funct, rot, shamt, rs, rt, rd_in, out_ready,
        input  in_ready, out_valid, result, rd_out, err
    );

    modport slave (
        input  in_valid, funct, rot, shamt, rs, rt, rd_in, out_ready,
        output in_ready, out_valid, result, rd_out, err
    );

endinterface

// File: rtl/shift_exec_stage_shifter.sv
// Combinational 32-bit log shifter (SHIFTER_32): five conditional stages of 1/2/4/8/16.
module shifter_32
    import shift_exec_stage_pkg::*;
(
    input  logic [XLEN-1:0] d,
    input  logic [4:0]      sa,
    input  logic            right,
    input  logic            arith,
    output logic [XLEN-1:0] sh
);

    logic [5:0][XLEN-1:0] stage;
    logic                 fill;

    assign fill     = arith & d[XLEN-1];
    assign stage[0] = d;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = !sa[gi] ? stage[gi] :
                                 right   ? {{SH{fill}}, stage[gi][XLEN-1:SH]} :
                                           {stage[gi][XLEN-1-SH:0], {SH{1'b0}}};
        end
    endgenerate

    assign sh = stage[5];

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage shift unit: decodes the funct, drives one shared shifter and
// registers the result with backpressure. SHIFT_EXEC_ROTATE_EN adds ROTR/ROTRV.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
(
    input  logic               clk,
    input  logic               clrn,
    shift_exec_stage_if.slave  bus
);

    state_t          state_reg, state_next;
    logic            in_ready_c, out_valid_c, accept;
    logic            legal, right, arith, var_amt;
    logic [4:0]      amt;
    logic            rot_start, in_rot;
    logic [XLEN-1:0] sh_d, sh_out, rot_tmp;
    logic [4:0]      sh_sa;
    logic            sh_right, sh_arith;
    logic [RAW-1:0]  rot_rd;
    logic [XLEN-1:0] result_reg;
    logic [RAW-1:0]  rd_out_reg;
    logic            err_reg;
    logic            unused_bits;

    always_comb begin
        legal   = 1'b1;
        right   = 1'b0;
        arith   = 1'b0;
        var_amt = 1'b0;
        case (bus.funct)
            FN_SLL:  ;
            FN_SRL:  right = 1'b1;
            FN_SRA:  begin right = 1'b1; arith = 1'b1; end
            FN_SLLV: var_amt = 1'b1;
            FN_SRLV: begin var_amt = 1'b1; right = 1'b1; end
            FN_SRAV: begin var_amt = 1'b1; right = 1'b1; arith = 1'b1; end
            default: legal = 1'b0;
        endcase
        amt = var_amt ? bus.rs[4:0] : bus.shamt;
    end

    assign accept = bus.in_valid & in_ready_c;

`ifdef SHIFT_EXEC_ROTATE_EN
    logic [XLEN-1:0] tmp_reg, rot_rt_reg;
    logic [4:0]      rot_n_reg;
    logic [RAW-1:0]  rot_rd_reg;

    // A zero-amount rotate is just Rt, so it takes the single-cycle path.
    assign rot_start = accept & legal & right & ~arith & bus.rot & (amt != 5'd0);
    assign in_rot    = (state_reg == ST_ROT);
    assign rot_tmp   = tmp_reg;
    assign rot_rd    = rot_rd_reg;

    assign sh_d     = in_rot ? rot_rt_reg : bus.rt;
    assign sh_sa    = in_rot ? rot_n_reg  : amt;
    assign sh_right = in_rot ? 1'b0       : right;
    assign sh_arith = in_rot ? 1'b0       : arith;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            tmp_reg    <= '0;
            rot_rt_reg <= '0;
            rot_n_reg  <= '0;
            rot_rd_reg <= '0;
        end else if (rot_start) begin
            tmp_reg    <= sh_out;
            rot_rt_reg <= bus.rt;
            rot_n_reg  <= rot_back_amt(amt);
            rot_rd_reg <= bus.rd_in;
        end
    end

    assign unused_bits = ^{bus.rs[XLEN-1:5]};
`else
    assign rot_start = 1'b0;
    assign in_rot    = 1'b0;
    assign rot_tmp   = '0;
    assign rot_rd    = '0;

    assign sh_d     = bus.rt;
    assign sh_sa    = amt;
    assign sh_right = right;
    assign sh_arith = arith;

    assign unused_bits = ^{bus.rs[XLEN-1:5], bus.rot};
`endif

    shifter_32 u_shifter (
        .d     (sh_d),
        .sa    (sh_sa),
        .right (sh_right),
        .arith (sh_arith),
        .sh    (sh_out)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_HOLD: begin
                if (accept)
                    state_next = rot_start ? ST_ROT : ST_HOLD;
                else if (state_reg == ST_HOLD && bus.out_ready)
                    state_next = ST_IDLE;
            end
            ST_ROT:  state_next = ST_HOLD;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = (state_reg == ST_IDLE) | ((state_reg == ST_HOLD) & bus.out_ready);
        out_valid_c = (state_reg == ST_HOLD);
    end

    // The ROT pass reuses the shifter for Rt<<n and merges it with the first pass.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            result_reg <= '0;
            rd_out_reg <= '0;
            err_reg    <= 1'b0;
        end else if (in_rot) begin
            result_reg <= rot_tmp | sh_out;
            rd_out_reg <= rot_rd;
            err_reg    <= 1'b0;
        end else if (accept && !rot_start) begin
            result_reg <= legal ? sh_out : '0;
            rd_out_reg <= bus.rd_in;
            err_reg    <= ~legal;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_reg;
    assign bus.rd_out    = rd_out_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage with a cycle-level reference model; honours SHIFT_EXEC_ROTATE_EN.
module tb_shift_exec_stage;
    import shift_exec_stage_pkg::*;

`ifdef SHIFT_EXEC_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clrn = 1'b0;
    shift_exec_stage_if bus();

    shift_exec_stage dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        err;
        int          rc;
    } exp_t;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // What the stage must produce for one op, straight from the instruction semantics.
    function automatic void model_op(input logic [5:0] f, input logic r, input logic [4:0] shamt,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     output logic [31:0] res, output logic err, output int lat);
        int a;
        a   = f[2] ? int'(rs[4:0]) : int'(shamt);
        err = 1'b0;
        lat = 1;
        case (f)
            6'h00, 6'h04: res = rt << a;
            6'h02, 6'h06: begin
                if (ROT_EN && r) begin
                    res = (rt >> a) | (rt << (32 - a));
                    lat = (a == 0) ? 1 : 2;
                end else begin
                    res = rt >> a;
                end
            end
            6'h03, 6'h07: res = $signed(rt) >>> a;
            default: begin res = 32'h0; err = 1'b1; end
        endcase
    endfunction

    always @(negedge clk) begin : mon
        bit   ev, eir;
        exp_t e;
        int   lat;
        if (!clrn) begin
            q.delete();
        end else begin
            ev  = (q.size() > 0) && (q[0].rc <= cyc);
            eir = (q.size() == 0) || (ev && bus.out_ready);
            chk("mon out_valid", 32'(bus.out_valid), 32'(ev));
            chk("mon in_ready", 32'(bus.in_ready), 32'(eir));
            if (ev && bus.out_valid) begin
                chk("mon result", bus.result, q[0].res);
                chk("mon rd_out", 32'(bus.rd_out), 32'(q[0].rd));
                chk("mon err", 32'(bus.err), 32'(q[0].err));
            end
            if (ev && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && eir) begin
                model_op(bus.funct, bus.rot, bus.shamt, bus.rs, bus.rt, e.res, e.err, lat);
                e.rd = bus.rd_in;
                e.rc = cyc + lat;
                q.push_back(e);
            end
        end
    end

    task automatic set_op(input logic [5:0] f, input logic r, input logic [4:0] sh,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        bus.funct    = f;
        bus.rot      = r;
        bus.shamt    = sh;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd_in    = rd;
        bus.in_valid = 1'b1;
    endtask

    // Presents an op and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [5:0] f, input logic r, input logic [4:0] sh,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
        int n;
        @(posedge clk); #1;
        set_op(f, r, sh, rs, rt, rd);
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send accepted", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] res,
                              input logic [4:0] rd, input logic err);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, " result"}, bus.result, res);
        chk({name, " rd_out"}, 32'(bus.rd_out), 32'(rd));
        chk({name, " err"}, 32'(bus.err), 32'(err));
    endtask

    logic [5:0]  tf  [10] = '{6'h00, 6'h02, 6'h03, 6'h07, 6'h3F, 6'h06, 6'h04, 6'h02, 6'h03, 6'h02};
    logic        trot[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0]  tsh [10] = '{5'd3, 5'd12, 5'd7, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd31, 5'd16};
    logic [31:0] trs [10] = '{32'h0, 32'h0, 32'h0, 32'h45, 32'h0, 32'h3B, 32'hFFFFFFE9, 32'h0, 32'h0, 32'h0};
    logic [31:0] trt [10] = '{32'h0000_00FF, 32'hABCD_1234, 32'h8765_4321, 32'hC000_0000, 32'h1111_1111,
                              32'h0F0F_00F1, 32'h0000_0003, 32'h5A5A_0001, 32'h7FFF_FFFF, 32'hFFFF_0000};

    initial begin
        int i, k;
        bit acc;
        bus.in_valid  = 1'b0;
        bus.funct     = '0;
        bus.rot       = 1'b0;
        bus.shamt     = '0;
        bus.rs        = '0;
        bus.rt        = '0;
        bus.rd_in     = '0;
        bus.out_ready = 1'b1;
        clrn          = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset result", bus.result, 32'h0);
        chk("reset rd_out", 32'(bus.rd_out), 32'd0);
        chk("reset err", 32'(bus.err), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        clrn = 1'b1;

        // SRA with exact one-cycle latency
        send(6'b000011, 1'b0, 5'd4, 32'h0, 32'h8000_0000, 5'd9);
        @(negedge clk);
        chk("sra out_valid", 32'(bus.out_valid), 32'd1);
        chk("sra result", bus.result, 32'hF800_0000);
        chk("sra rd_out", 32'(bus.rd_out), 32'd9);

        send(6'b000110, 1'b0, 5'd0, 32'h0000_0024, 32'hF000_0000, 5'd3);
        expect_out("srlv", 32'h0F00_0000, 5'd3, 1'b0);
        send(6'b000000, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF, 5'd4);
        expect_out("sll0", 32'hDEAD_BEEF, 5'd4, 1'b0);
        send(6'b000111, 1'b0, 5'd0, 32'h0000_001F, 32'h8000_0001, 5'd6);
        expect_out("srav31", 32'hFFFF_FFFF, 5'd6, 1'b0);
        send(6'b000010, 1'b0, 5'd31, 32'h0, 32'h8000_0000, 5'd8);
        expect_out("srl31", 32'h0000_0001, 5'd8, 1'b0);
        send(6'b000100, 1'b0, 5'd0, 32'h0000_0020, 32'hA5A5_A5A5, 5'd10);
        expect_out("sllv32", 32'hA5A5_A5A5, 5'd10, 1'b0);

        // Backpressure: second op waits while the first result is held
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(6'b000000, 1'b0, 5'd1, 32'h0, 32'h1, 5'd1);
        set_op(6'b000000, 1'b0, 5'd2, 32'h0, 32'h1, 5'd2);
        repeat (3) begin
            @(negedge clk);
            chk("bp in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp result", bus.result, 32'h0000_0002);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp second result", bus.result, 32'h0000_0004);
        chk("bp second rd_out", 32'(bus.rd_out), 32'd2);
        @(negedge clk);
        chk("drain out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain result held", bus.result, 32'h0000_0004);

        send(6'b100000, 1'b0, 5'd0, 32'h0, 32'h1234_5678, 5'd7);
        expect_out("illegal", 32'h0, 5'd7, 1'b1);
        send(6'b000010, 1'b0, 5'd1, 32'h0, 32'h8, 5'd11);
        expect_out("after illegal", 32'h4, 5'd11, 1'b0);

        // Rotate right by 8
        send(6'b000010, 1'b1, 5'd8, 32'h0, 32'h1234_5678, 5'd5);
        @(negedge clk);
        if (ROT_EN) begin
            chk("rotr in_ready", 32'(bus.in_ready), 32'd0);
            chk("rotr pending", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            chk("rotr out_valid", 32'(bus.out_valid), 32'd1);
            chk("rotr result", bus.result, 32'h7812_3456);
        end else begin
            chk("srl rot ignored valid", 32'(bus.out_valid), 32'd1);
            chk("srl rot ignored result", bus.result, 32'h0012_3456);
        end
        send(6'b000110, 1'b1, 5'd0, 32'h4, 32'h0000_000F, 5'd12);
        expect_out("rotrv", ROT_EN ? 32'hF000_0000 : 32'h0, 5'd12, 1'b0);
        send(6'b000010, 1'b1, 5'd0, 32'h0, 32'hCAFE_F00D, 5'd13);
        expect_out("rotr0", 32'hCAFE_F00D, 5'd13, 1'b0);

        // Reset while a rotate is in flight
        send(6'b000010, 1'b1, 5'd8, 32'h0, 32'h1234_5678, 5'd14);
        clrn = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rot reset out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rot reset no output", 32'(bus.out_valid), 32'd0);
        end

        // Asynchronous reset in the middle of HOLD
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(6'b000000, 1'b0, 5'd3, 32'h0, 32'h1, 5'd15);
        @(negedge clk);
        chk("hold before reset", bus.result, 32'h0000_0008);
        #2;
        clrn = 1'b0;
        q.delete();
        #1;
        chk("async reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("async reset result", bus.result, 32'h0);
        chk("async reset rd_out", 32'(bus.rd_out), 32'd0);
        @(posedge clk); #1;
        clrn = 1'b1;
        bus.out_ready = 1'b1;

        // Streaming table with a periodic stall
        i = 0;
        k = 0;
        while (i < 10 && k < 200) begin
            set_op(tf[i], trot[i], tsh[i], trs[i], trt[i], 5'(i + 16));
            bus.out_ready = ((k % 4) != 3);
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            k++;
        end
        chk("stream completed", 32'(i), 32'd10);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("scoreboard empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-stage shift unit for the MIPS-style datapath.
- Accepts a decoded shift operation (funct, shamt, Rs, Rt, destination register) over a valid/ready handshake.
- Drives the existing combinational SHIFTER_32 controls (Sa, Arith, Right) and registers the result toward writeback with backpressure.
- Sits between decode/register-read and the writeback mux.

Parameters:
- XLEN, 32, datapath width; only 32 is supported, because SHIFTER_32 is fixed-width.
- RAW, 5, width of the register-number field carried alongside the op.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Clrn  input  1  asynchronous active-low reset.
- In_Valid  input  1  upstream op valid.
- In_Ready  output  1  stage can accept this cycle.
- Funct  input  6  MIPS funct field.
- Rot  input  1  rotate qualifier: instr[21] for ROTR, instr[6] for ROTRV.
- Shamt  input  5  immediate shift amount.
- Rs  input  XLEN  variable-amount source; low 5 bits are used.
- Rt  input  XLEN  operand to shift.
- Rd_In  input  RAW  destination register number.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  downstream accepts.
- Result  output  XLEN  shifted value.
- Rd_Out  output  RAW  destination register, registered with Result.
- Err  output  1  unsupported funct; qualified by Out_Valid.

Behaviour:
- Reset: Clrn=0 asynchronously forces state=IDLE, Out_Valid=0, Result=0, Rd_Out=0, Err=0, and clears the internal temp registers.
- Funct decode:
  - 000000 SLL: amt=Shamt, Right=0, Arith=0.
  - 000010 SRL: amt=Shamt, Right=1, Arith=0.
  - 000011 SRA: amt=Shamt, Right=1, Arith=1.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: same controls as SLL/SRL/SRA, with amt=Rs[4:0].
  - Any other funct is illegal: Result=0, Err=1.
- States:
  - IDLE: output register empty.
  - HOLD: Out_Valid=1, waiting for Out_Ready.
  - ROT: second shifter pass of a rotate; present only with ROTATE_EN.
- In_Ready = (state==IDLE) | (state==HOLD & Out_Ready). It is combinational and is 0 in ROT.
- Accept happens when In_Valid & In_Ready. For a non-rotate op on accept:
  - Next edge: Result = SHIFTER_32(Rt, amt, Arith, Right); Rd_Out=Rd_In; Err per decode; state becomes HOLD.
  - Latency is 1 cycle. Throughput is 1 op/cycle while Out_Ready=1.
- HOLD with Out_Ready=1 and no new accept: state→IDLE, Out_Valid→0. Result and Rd_Out hold their last value.
- HOLD with Out_Ready=0: Result, Rd_Out and Err are held stable; In_Ready=0.
- Simultaneous drain and accept in HOLD: the new result replaces the old one on the same edge; Out_Valid stays 1.
- amt=0: the result equals Rt for every op.
- SRA/SRAV fill with Rt[31]. Logical shifts fill with 0.
- Mid-operation reset: any in-flight op, including a rotate in ROT, is discarded with no output.

Optional Feature:
- Macro: SHIFT_EXEC_ROTATE_EN.
- When defined, SRL/SRLV with Rot=1 execute ROTR/ROTRV.
  - amt≠0:
    - Accept cycle: the shifter computes Rt>>amt (logical). The stage latches it into tmp, and latches Rt and n=(32-amt) mod 32. State→ROT, Out_Valid=0.
    - ROT cycle: the same SHIFTER_32 instance, with muxed inputs, computes Rt<<n. On the next edge Result=tmp | that value; state→HOLD.
    - Latency is 2 cycles.
  - amt=0: single-cycle, Result=Rt.
  - Only one SHIFTER_32 instance exists.
- When undefined: Rot is ignored, SRL/SRLV behave as logical shifts, and the ROT state and tmp registers are not generated.

Decomposition:
- Shared header shift_defs.vh (`define constants): funct codes (SLL, SRL, SRA, SLLV, SRLV, SRAV) and state encodings (IDLE=2'd0, HOLD=2'd1, ROT=2'd2).
- One sub-module: the existing SHIFTER_32, instantiated once. Its inputs are muxed between the input port and the ROT temporaries.
- Decode stays inline in this block.

Test Plan:
- Reset: hold Clrn=0 → Out_Valid=0, Result=0, Rd_Out=0, Err=0, In_Ready=1. Pull Clrn low asynchronously mid-HOLD → Out_Valid drops immediately.
- SRA: Funct=000011, Rt=0x80000000, Shamt=4, Rd_In=9 → one cycle later Out_Valid=1, Result=0xF8000000, Rd_Out=9.
- SRLV: Rs=0x00000024, Rt=0xF0000000 → Result=0x0F000000 (only Rs[4:0]=4 is used). SLL Shamt=0, Rt=0xDEADBEEF → Result=0xDEADBEEF.
- Backpressure: two back-to-back SLLs of Rt=1 (Shamt=1, then Shamt=2) with Out_Ready=0 for 3 cycles.
  - Result holds 0x00000002 and In_Ready=0 throughout.
  - Out_Ready→1: the second op is accepted the same cycle, and Result becomes 0x00000004 next edge.
- Illegal: Funct=100000 → Out_Valid=1, Err=1, Result=0. Next legal op clears Err.
- Rotate (SHIFT_EXEC_ROTATE_EN): ROTR Rt=0x12345678, Shamt=8, Rot=1.
  - In_Ready=0 for 1 cycle; Result=0x78123456 two cycles after accept.
  - Repeat with Clrn pulsed during ROT → no Out_Valid.
  - Without the macro, the same stimulus gives Result=0x00123456.
